// File: rtl/abuf_load_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : abuf_load_ctrl_if
// Description : Handshake bundle of the abuf load controller. Carries the
//               scheduler command, the DDR-to-abuf loader configuration and
//               the DDR read request.
//               master : the load controller
//               slave  : the environment (scheduler, loader, DDR read engine)
// Revision    : 1.0 - initial release
// ============================================================================
interface abuf_load_ctrl_if #(
    parameter int PE_NUM = 32,
    parameter int DDR_AW = 32
);
    // Command from the layer scheduler
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [3:0]            cmd_phase_en;
    logic [4*DDR_AW-1:0]   cmd_addr;
    logic [4*16-1:0]       cmd_num;
    logic [PE_NUM-1:0]     cmd_mask;

    // Loader configuration
    logic                  conf_valid;
    logic                  conf_ready;
    logic [1:0]            conf_trans_type;
    logic [15:0]           conf_trans_num;
    logic [PE_NUM-1:0]     conf_mask;

    // DDR read request
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DDR_AW-1:0]     rd_addr;
    logic [16:0]           rd_len;

    modport master (
        input  cmd_valid, cmd_phase_en, cmd_addr, cmd_num, cmd_mask,
        output cmd_ready,
        output conf_valid, conf_trans_type, conf_trans_num, conf_mask,
        input  conf_ready,
        output rd_valid, rd_addr, rd_len,
        input  rd_ready
    );

    modport slave (
        output cmd_valid, cmd_phase_en, cmd_addr, cmd_num, cmd_mask,
        input  cmd_ready,
        input  conf_valid, conf_trans_type, conf_trans_num, conf_mask,
        output conf_ready,
        input  rd_valid, rd_addr, rd_len,
        output rd_ready
    );
endinterface
`default_nettype wire

// File: rtl/abuf_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : abuf_load_ctrl
// Description : Sequences one accumulation/bias buffer load. Walks the four
//               transfer phases (accum data, accum tail, bias data, bias
//               tail) in order; for each active phase it configures the
//               loader, issues the DDR read and waits for the loader to
//               finish. Optional cycle counter enabled by the macro
//               ABUF_LOAD_CTRL_PERF_EN (perf_cycles tied to 0 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module abuf_load_ctrl #(
    parameter int PE_NUM     = 32,
    parameter int DDR_AW     = 32,
    parameter int BEAT_BYTES = 32     // must be a power of two
) (
    input  wire logic           clk,
    input  wire logic           rst,          // asynchronous, active-low
    abuf_load_ctrl_if.master    bus,
    output logic                busy,
    output logic                done,
    output logic [31:0]         perf_cycles
);

    localparam logic [16:0] c_beat_m1 = 17'(BEAT_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEL       = 3'd1,
        S_CONF      = 3'd2,
        S_RDREQ     = 3'd3,
        S_WAIT_BUSY = 3'd4,
        S_WAIT_DONE = 3'd5,
        S_FIN       = 3'd6
    } state_t;

    state_t                 r_state;
    logic [1:0]             r_p;
    logic [3:0]             r_en;
    logic [4*DDR_AW-1:0]    r_addr;
    logic [4*16-1:0]        r_num;
    logic [PE_NUM-1:0]      r_mask;

    logic                   r_cmd_ready;
    logic                   r_conf_valid;
    logic [1:0]             r_conf_type;
    logic [15:0]            r_conf_num;
    logic [PE_NUM-1:0]      r_conf_mask;
    logic                   r_rd_valid;
    logic [DDR_AW-1:0]      r_rd_addr;
    logic [16:0]            r_rd_len;
    logic                   r_busy;
    logic                   r_done;

    logic [15:0]            w_num_p;
    logic [DDR_AW-1:0]      w_addr_p;
    logic                   w_active;
    logic [16:0]            w_len_p;
    logic                   w_accept;

    // Select the latched fields of the current phase
    always_comb begin
        w_addr_p = r_addr[0 +: DDR_AW];
        case (r_p)
            2'd0:    w_addr_p = r_addr[0*DDR_AW +: DDR_AW];
            2'd1:    w_addr_p = r_addr[1*DDR_AW +: DDR_AW];
            2'd2:    w_addr_p = r_addr[2*DDR_AW +: DDR_AW];
            default: w_addr_p = r_addr[3*DDR_AW +: DDR_AW];
        endcase
    end

    assign w_num_p  = r_num[{r_p, 4'b0000} +: 16];
    assign w_active = r_en[r_p] && (w_num_p != 16'd0);
    // 17-bit sum so a 0xFFFF byte count rounds to 0x10000 without wrapping
    assign w_len_p  = ({1'b0, w_num_p} + c_beat_m1) & ~c_beat_m1;
    assign w_accept = bus.cmd_valid && r_cmd_ready;

    // Phase sequencer with registered handshake and status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_p          <= 2'd0;
            r_en         <= 4'd0;
            r_addr       <= '0;
            r_num        <= '0;
            r_mask       <= '0;
            r_cmd_ready  <= 1'b1;
            r_conf_valid <= 1'b0;
            r_conf_type  <= 2'd0;
            r_conf_num   <= 16'd0;
            r_conf_mask  <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_addr    <= '0;
            r_rd_len     <= 17'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_en        <= bus.cmd_phase_en;
                        r_addr      <= bus.cmd_addr;
                        r_num       <= bus.cmd_num;
                        r_mask      <= bus.cmd_mask;
                        r_p         <= 2'd0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_SEL;
                    end
                end
                S_SEL: begin
                    if (w_active) begin
                        r_conf_valid <= 1'b1;
                        r_conf_type  <= r_p;
                        r_conf_num   <= w_num_p;
                        r_conf_mask  <= r_mask;
                        r_state      <= S_CONF;
                    end else if (r_p == 2'd3) begin
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end else begin
                        r_p <= r_p + 2'd1;
                    end
                end
                S_CONF: begin
                    // Configuration lands first so the loader counters are
                    // cleared before any read data can arrive
                    if (bus.conf_ready) begin
                        r_conf_valid <= 1'b0;
                        r_rd_valid   <= 1'b1;
                        r_rd_addr    <= w_addr_p;
                        r_rd_len     <= w_len_p;
                        r_state      <= S_RDREQ;
                    end
                end
                S_RDREQ: begin
                    if (bus.rd_ready) begin
                        r_rd_valid <= 1'b0;
                        r_state    <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (!bus.conf_ready) begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (bus.conf_ready) begin
                        if (r_p == 2'd3) begin
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_p     <= r_p + 2'd1;
                            r_state <= S_SEL;
                        end
                    end
                end
                S_FIN: begin
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_conf_valid <= 1'b0;
                    r_rd_valid   <= 1'b0;
                    r_busy       <= 1'b0;
                    r_cmd_ready  <= 1'b1;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready       = r_cmd_ready;
    assign bus.conf_valid      = r_conf_valid;
    assign bus.conf_trans_type = r_conf_type;
    assign bus.conf_trans_num  = r_conf_num;
    assign bus.conf_mask       = r_conf_mask;
    assign bus.rd_valid        = r_rd_valid;
    assign bus.rd_addr         = r_rd_addr;
    assign bus.rd_len          = r_rd_len;
    assign busy                = r_busy;
    assign done                = r_done;

`ifdef ABUF_LOAD_CTRL_PERF_EN
    logic [31:0] r_perf_cnt;
    logic [31:0] r_perf_out;
    logic [31:0] w_perf_inc;

    assign w_perf_inc = (r_perf_cnt == 32'hFFFF_FFFF) ? r_perf_cnt : r_perf_cnt + 32'd1;

    // Command duration counter; the accept cycle counts as the first cycle
    // and the FIN cycle as the last, saturating at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_cnt <= 32'd0;
            r_perf_out <= 32'd0;
        end else begin
            if (r_state == S_IDLE && w_accept) begin
                r_perf_cnt <= 32'd1;
            end else if (r_busy) begin
                r_perf_cnt <= w_perf_inc;
            end
            if (r_state == S_FIN) begin
                r_perf_out <= w_perf_inc;
            end
        end
    end

    assign perf_cycles = r_perf_out;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_abuf_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_abuf_load_ctrl
// Description : Scoreboard bench for abuf_load_ctrl. Stimulus pushes the
//               hand-computed loader configurations, DDR reads and done
//               pulses it expects; a monitor pops them on each handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_abuf_load_ctrl;

    localparam int PE_NUM     = 32;
    localparam int DDR_AW     = 32;
    localparam int BEAT_BYTES = 32;
`ifdef ABUF_LOAD_CTRL_PERF_EN
    localparam logic [31:0] c_exp_perf_empty = 32'd6;
`else
    localparam logic [31:0] c_exp_perf_empty = 32'd0;
`endif

    typedef struct packed {
        logic [1:0]  t;
        logic [15:0] n;
        logic [31:0] m;
    } conf_t;

    typedef struct packed {
        logic [31:0] a;
        logic [16:0] l;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] perf_cycles;

    logic        ld_busy    = 1'b0;
    logic        conf_stall = 1'b0;
    logic        rd_stall   = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc   = 0;
    int done_cyc  = 0;
    int done_cnt  = 0;
    int exp_done  = 0;

    conf_t exp_conf[$];
    rd_t   exp_rd[$];
    conf_t ec;
    rd_t   er;

    abuf_load_ctrl_if #(.PE_NUM(PE_NUM), .DDR_AW(DDR_AW)) bus ();

    abuf_load_ctrl #(
        .PE_NUM     (PE_NUM),
        .DDR_AW     (DDR_AW),
        .BEAT_BYTES (BEAT_BYTES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .perf_cycles (perf_cycles)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.conf_ready = !ld_busy && !conf_stall;
    assign bus.rd_ready   = !rd_stall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    // Loader model: busy 1 cycle after accepting a configuration, idle 10 later
    initial forever begin
        @(negedge clk);
        if (rst && bus.conf_valid && bus.conf_ready) begin
            @(posedge clk);
            @(posedge clk);
            #1 ld_busy = 1'b1;
            repeat (10) @(posedge clk);
            #1 ld_busy = 1'b0;
        end
    end

    // Monitor: protocol checks every cycle and scoreboard pops on handshakes
    logic        p_cv = 1'b0, p_cr = 1'b0, p_rv = 1'b0, p_rr = 1'b0, p_done = 1'b0;
    logic [1:0]  p_ct;
    logic [15:0] p_cn;
    logic [31:0] p_cm, p_ra;
    logic [16:0] p_rl;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            p_cv = 1'b0; p_rv = 1'b0; p_done = 1'b0;
        end else begin
            if (p_cv && !p_cr)
                chk("conf_hold", {13'd0, bus.conf_valid, bus.conf_trans_type, bus.conf_trans_num, bus.conf_mask},
                                 {13'd0, 1'b1, p_ct, p_cn, p_cm});
            if (p_rv && !p_rr)
                chk("rd_hold", {14'd0, bus.rd_valid, bus.rd_addr, bus.rd_len}, {14'd0, 1'b1, p_ra, p_rl});
            chk("conf_rd_overlap", 64'(bus.conf_valid && bus.rd_valid), 64'd0);
            chk("cmd_ready_vs_busy", 64'(bus.cmd_ready), 64'(!busy));
            if (!busy || done)
                chk("valid_outside_xfer", {62'd0, bus.conf_valid, bus.rd_valid}, 64'd0);
            if (bus.conf_valid && bus.conf_ready) begin
                if (exp_conf.size() == 0) begin
                    chk("conf_unexpected", 64'(exp_conf.size()), 64'd1);
                end else begin
                    ec = exp_conf.pop_front();
                    chk("conf_type", 64'(bus.conf_trans_type), 64'(ec.t));
                    chk("conf_num",  64'(bus.conf_trans_num),  64'(ec.n));
                    chk("conf_mask", 64'(bus.conf_mask),       64'(ec.m));
                end
            end
            if (bus.rd_valid && bus.rd_ready) begin
                if (exp_rd.size() == 0) begin
                    chk("rd_unexpected", 64'(exp_rd.size()), 64'd1);
                end else begin
                    er = exp_rd.pop_front();
                    chk("rd_addr", 64'(bus.rd_addr), 64'(er.a));
                    chk("rd_len",  64'(bus.rd_len),  64'(er.l));
                end
            end
            if (done) begin
                chk("done_one_cycle", 64'(p_done), 64'd0);
                if (exp_done == 0) chk("done_unexpected", 64'(exp_done), 64'd1);
                else exp_done--;
                done_cnt++;
                done_cyc = cyc;
            end
            p_cv = bus.conf_valid; p_cr = bus.conf_ready;
            p_ct = bus.conf_trans_type; p_cn = bus.conf_trans_num; p_cm = bus.conf_mask;
            p_rv = bus.rd_valid; p_rr = bus.rd_ready;
            p_ra = bus.rd_addr; p_rl = bus.rd_len;
            p_done = done;
        end
    end

    task automatic expect_phase(input logic [1:0] t, input logic [15:0] n, input logic [31:0] a,
                                input logic [16:0] l, input logic [31:0] m);
        exp_conf.push_back('{t: t, n: n, m: m});
        exp_rd.push_back('{a: a, l: l});
    endtask

    // Drive a command until accepted, then scramble the inputs
    task automatic send_cmd(input logic [3:0] en, input logic [127:0] addr,
                            input logic [63:0] num, input logic [31:0] mask);
        int n = 0;
        exp_done++;
        bus.cmd_phase_en = en;
        bus.cmd_addr     = addr;
        bus.cmd_num      = num;
        bus.cmd_mask     = mask;
        bus.cmd_valid    = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.cmd_ready && n < 200);
        chk("cmd_accept", 64'(bus.cmd_ready), 64'd1);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        bus.cmd_valid    = 1'b0;
        bus.cmd_phase_en = ~en;
        bus.cmd_addr     = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.cmd_num      = {$urandom(), $urandom()} | 64'h0001_0001_0001_0001;
        bus.cmd_mask     = $urandom();
    endtask

    task automatic wait_done(input string name);
        int tgt = done_cnt + 1;
        int n   = 0;
        while (done_cnt < tgt && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, 64'(done_cnt), 64'(tgt));
        chk({name, "_conf_left"}, 64'(exp_conf.size()), 64'd0);
        chk({name, "_rd_left"},   64'(exp_rd.size()),   64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pre;
        bus.cmd_valid    = 1'b0;
        bus.cmd_phase_en = 4'd0;
        bus.cmd_addr     = '0;
        bus.cmd_num      = '0;
        bus.cmd_mask     = '0;

        // Reset state
        @(posedge clk);
        #2;
        chk("reset_outputs", {bus.conf_valid, bus.rd_valid, busy, done, bus.conf_trans_type,
                              bus.conf_trans_num, bus.conf_mask[9:0]}, 64'd0);
        chk("reset_data", {bus.rd_addr, bus.rd_len, 15'd0}, 64'd0);
        chk("reset_perf", 64'(perf_cycles), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_reset", 64'(bus.cmd_ready), 64'd1);
        @(posedge clk);
        #1;

        // 1: all four phases, rd_len 64,128,32,64
        expect_phase(2'd0, 16'd64,  32'h1000_0000, 17'd64,  32'hA5A5_F00F);
        expect_phase(2'd1, 16'd128, 32'h1000_1000, 17'd128, 32'hA5A5_F00F);
        expect_phase(2'd2, 16'd32,  32'h2000_0000, 17'd32,  32'hA5A5_F00F);
        expect_phase(2'd3, 16'd33,  32'h2000_0040, 17'd64,  32'hA5A5_F00F);
        send_cmd(4'b1111, {32'h2000_0040, 32'h2000_0000, 32'h1000_1000, 32'h1000_0000},
                 {16'd33, 16'd32, 16'd128, 16'd64}, 32'hA5A5_F00F);
        wait_done("t1_done");

        // 2a: phase_en 1010, num[2]=0, num[3]=0 -> only phase 1
        expect_phase(2'd1, 16'd100, 32'h0000_4000, 17'd128, 32'h0000_00FF);
        send_cmd(4'b1010, {32'h0000_C000, 32'h0000_8000, 32'h0000_4000, 32'h0000_0000},
                 {16'd0, 16'd0, 16'd100, 16'd16}, 32'h0000_00FF);
        wait_done("t2a_done");

        // 2b: phase_en 1010, num[3]=40 -> phases 1 and 3
        expect_phase(2'd1, 16'd1,  32'h0000_4000, 17'd32, 32'hFFFF_0000);
        expect_phase(2'd3, 16'd40, 32'h0000_C000, 17'd64, 32'hFFFF_0000);
        send_cmd(4'b1010, {32'h0000_C000, 32'h0000_8000, 32'h0000_4000, 32'h0000_0000},
                 {16'd40, 16'd0, 16'd1, 16'd16}, 32'hFFFF_0000);
        wait_done("t2b_done");

        // 2c: enabled phase with num 0 skipped; 0xFFFF rounds to 0x10000
        expect_phase(2'd1, 16'd31,     32'h0A00_0000, 17'd32,      32'h1234_5678);
        expect_phase(2'd2, 16'hFFFF,   32'h0B00_0000, 17'h1_0000,  32'h1234_5678);
        send_cmd(4'b1111, {32'h0C00_0000, 32'h0B00_0000, 32'h0A00_0000, 32'h0900_0000},
                 {16'd0, 16'hFFFF, 16'd31, 16'd0}, 32'h1234_5678);
        wait_done("t2c_done");

        // 3: no active phase -> done in the 6th cycle counting the accept cycle
        send_cmd(4'b0000, '0, {16'd5, 16'd5, 16'd5, 16'd5}, 32'hFFFF_FFFF);
        wait_done("t3_done");
        chk("t3_done_latency", 64'(done_cyc - acc_cyc), 64'd5);
        chk("t3_perf", 64'(perf_cycles), 64'(c_exp_perf_empty));
        chk("t3_cmd_ready", 64'(bus.cmd_ready), 64'd1);

        // 4: backpressure on configuration (5 cycles) and read (7 cycles)
        conf_stall = 1'b1;
        rd_stall   = 1'b1;
        expect_phase(2'd0, 16'd200, 32'h3000_0000, 17'd224, 32'h0F0F_0F0F);
        send_cmd(4'b0001, {96'd0, 32'h3000_0000}, {48'd0, 16'd200}, 32'h0F0F_0F0F);
        n = 0;
        while (!bus.conf_valid && n < 50) begin @(posedge clk); #1; n++; end
        repeat (5) @(posedge clk);
        #1;
        chk("t4_conf_held", {62'd0, bus.conf_valid, bus.rd_valid}, 64'd2);
        conf_stall = 1'b0;
        n = 0;
        while (!bus.rd_valid && n < 50) begin @(posedge clk); #1; n++; end
        repeat (7) @(posedge clk);
        #1;
        chk("t4_rd_held", {62'd0, bus.conf_valid, bus.rd_valid}, 64'd1);
        rd_stall = 1'b0;
        wait_done("t4_done");

        // 5: asynchronous reset during WAIT_DONE of phase 1
        expect_phase(2'd0, 16'd64,  32'h1000_0000, 17'd64,  32'hA5A5_F00F);
        expect_phase(2'd1, 16'd128, 32'h1000_1000, 17'd128, 32'hA5A5_F00F);
        expect_phase(2'd2, 16'd32,  32'h2000_0000, 17'd32,  32'hA5A5_F00F);
        expect_phase(2'd3, 16'd33,  32'h2000_0040, 17'd64,  32'hA5A5_F00F);
        send_cmd(4'b1111, {32'h2000_0040, 32'h2000_0000, 32'h1000_1000, 32'h1000_0000},
                 {16'd33, 16'd32, 16'd128, 16'd64}, 32'hA5A5_F00F);
        n = 0;
        while (!(exp_rd.size() == 2 && ld_busy) && n < 200) begin @(posedge clk); #1; n++; end
        chk("t5_reached_phase1", 64'(exp_rd.size()), 64'd2);
        repeat (2) @(posedge clk);
        pre = done_cnt;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t5_async_reset", {bus.conf_valid, bus.rd_valid, busy, done, bus.conf_trans_type,
                               bus.conf_trans_num, bus.conf_mask[9:0]}, 64'd0);
        chk("t5_async_reset_data", {bus.rd_addr, bus.rd_len, 15'd0}, 64'd0);
        exp_conf.delete();
        exp_rd.delete();
        exp_done = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        n = 0;
        while (ld_busy && n < 50) begin @(posedge clk); #1; n++; end
        repeat (3) @(posedge clk);
        #1;
        chk("t5_no_done", 64'(done_cnt), 64'(pre));
        chk("t5_idle", {62'd0, busy, bus.cmd_ready}, 64'd1);
        expect_phase(2'd0, 16'd16, 32'h5000_0000, 17'd32, 32'h8000_0001);
        expect_phase(2'd1, 16'd64, 32'h5000_1000, 17'd64, 32'h8000_0001);
        send_cmd(4'b0011, {64'd0, 32'h5000_1000, 32'h5000_0000}, {32'd0, 16'd64, 16'd16}, 32'h8000_0001);
        wait_done("t5_restart_done");

        chk("final_done_pending", 64'(exp_done), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
